// File: rtl/block_deinterleaver_rx.sv
// Receive-side ROWS x COLS block deinterleaver: column-major serial bits in, row-major word out.
// Optional sync checking (sof mid-block flag plus hunt-for-sof) is built with DIL_SYNC_CHECK_EN.
module block_deinterleaver_rx #(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 7,
  localparam int unsigned N = ROWS * COLS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_en,
  input  logic         in_bit,
  input  logic         sof,
  output logic         out_en,
  output logic [N-1:0] data_out,
  output logic         sync_err
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned PW = $clog2(N);

`ifdef DIL_SYNC_CHECK_EN
  typedef enum logic [1:0] {StIdle, StFill, StHunt} state_e;
`else
  typedef enum logic [1:0] {StIdle, StFill} state_e;
`endif

  state_e        state_q, state_d;
  logic [RW-1:0] r_q, r_d, eff_r;
  logic [CW-1:0] c_q, c_d, eff_c;
  logic [N-1:0]  asm_q, asm_d, asm_new;
  logic [N-1:0]  data_q, data_d;
  logic          out_en_q, out_en_d;
  logic [PW-1:0] pos;
  int unsigned   idx;
  logic          last;
  logic          take;

`ifdef DIL_SYNC_CHECK_EN
  logic sync_err_q;
  logic err_set;
`endif

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    c_d      = c_q;
    asm_d    = asm_q;
    data_d   = data_q;
    out_en_d = 1'b0;
    take     = 1'b0;
`ifdef DIL_SYNC_CHECK_EN
    err_set  = 1'b0;
`endif
    // An accepted sof forces this bit to k = 0, dropping any partial block.
    eff_r   = sof ? '0 : r_q;
    eff_c   = sof ? '0 : c_q;
    idx     = 32'(eff_r) * COLS + 32'(eff_c);
    pos     = PW'(N - 1 - idx);
    last    = (eff_r == RW'(ROWS - 1)) && (eff_c == CW'(COLS - 1));
    asm_new = asm_q;
    asm_new[pos] = in_bit;

    if (in_en) begin
      take = 1'b1;
`ifdef DIL_SYNC_CHECK_EN
      if (sof && state_q == StFill) err_set = 1'b1;
      if (!sof && state_q == StHunt) take = 1'b0;
      if (!sof && state_q == StIdle && sync_err_q) begin
        take    = 1'b0;
        state_d = StHunt;
      end
`endif
      if (take) begin
        asm_d = asm_new;
        if (last) begin
          data_d   = asm_new;
          out_en_d = 1'b1;
          state_d  = StIdle;
          r_d      = '0;
          c_d      = '0;
        end else begin
          state_d = StFill;
          if (eff_r == RW'(ROWS - 1)) begin
            r_d = '0;
            c_d = eff_c + 1'b1;
          end else begin
            r_d = eff_r + 1'b1;
            c_d = eff_c;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      r_q      <= '0;
      c_q      <= '0;
      asm_q    <= '0;
      data_q   <= '0;
      out_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      c_q      <= c_d;
      asm_q    <= asm_d;
      data_q   <= data_d;
      out_en_q <= out_en_d;
    end
  end

`ifdef DIL_SYNC_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_err_q <= 1'b0;
    end else if (err_set) begin
      sync_err_q <= 1'b1;
    end
  end

  assign sync_err = sync_err_q;
`else
  assign sync_err = 1'b0;
`endif

  assign out_en   = out_en_q;
  assign data_out = data_q;

endmodule
